// File: rtl/stream_buf_pkg.sv
// Shared defaults, the beat type and the wrap-around pointer helper for the
// multi-word stream buffer.
package stream_buf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LANES_DEF  = 2;

    typedef logic [LANES_DEF*DATA_W_DEF-1:0] beat_t;

    // Wrapping add for power-of-two depths; callers truncate to their pointer width.
    function automatic logic [31:0] ptr_add(input logic [31:0] ptr,
                                            input logic [31:0] n,
                                            input logic [31:0] depth);
        return (ptr + n) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/stream_buf_mem.sv
// Word-wide storage with one write port and LANES read ports at consecutive
// wrapped addresses. Masked-off lanes read as zero so drain beats come out padded.
module stream_buf_mem
    import stream_buf_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 16384,
    parameter  int LANES  = LANES_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [LANES-1:0]        rd_mask,
    output logic [LANES*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Single write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Lane g reads rd_addr+g; lane 0 (oldest word) lands in the top slice.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [ADDR_W-1:0] lane_addr;
        assign lane_addr = ADDR_W'(ptr_add(32'(rd_addr), 32'(g), 32'(DEPTH)));
        assign rd_data[(LANES-1-g)*DATA_W +: DATA_W] = rd_mask[g] ? mem_q[lane_addr] : '0;
    end

endmodule

// File: rtl/stream_buffer_mw.sv
// Circular FIFO taking one word per cycle and emitting LANES consecutive words
// per beat through a registered valid/ready output stage, with flush and a
// drain mode that releases a zero-padded partial beat.
module stream_buffer_mw
    import stream_buf_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 16384,
    parameter  int LANES  = LANES_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [LANES*DATA_W-1:0] rd_data,
    input  logic                    flush,
    input  logic                    drain,
    output logic [ADDR_W:0]         count,
    output logic                    full,
    output logic                    empty
);

    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]         count_q, count_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [LANES*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [LANES*DATA_W-1:0] mem_rd_data;
    logic [LANES-1:0]        lane_mask;
    logic [ADDR_W:0]         n_load;
    logic                    wr_acc, slot_free, load_full, load_drain, load;

    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign wr_ready  = !full;
    assign empty     = (count_q == '0) && !rd_valid_q;
    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

    // Load decisions look only at the registered count, so a word written this
    // edge becomes loadable on the next one.
    assign wr_acc     = wr_valid && !full;
    assign slot_free  = !rd_valid_q || rd_ready;
    assign load_full  = slot_free && (count_q >= (ADDR_W+1)'(LANES));
    assign load_drain = slot_free && drain && (count_q != '0) && (count_q < (ADDR_W+1)'(LANES));
    assign load       = load_full || load_drain;
    assign n_load     = load_full ? (ADDR_W+1)'(LANES) : (load_drain ? count_q : '0);

    for (genvar g = 0; g < LANES; g++) begin : g_mask
        assign lane_mask[g] = load_full || (load_drain && ((ADDR_W+1)'(g) < count_q));
    end

    stream_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !flush && !rst),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_mask (lane_mask),
        .rd_data (mem_rd_data)
    );

    // Next-state: flush wipes pointers/count/valid but keeps the last beat data.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ADDR_W'(ptr_add(32'(wr_ptr_q), 32'd1, 32'(DEPTH)));
            end
            if (load) begin
                rd_ptr_d   = ADDR_W'(ptr_add(32'(rd_ptr_q), 32'(n_load), 32'(DEPTH)));
                rd_valid_d = 1'b1;
                rd_data_d  = mem_rd_data;
            end else if (slot_free) begin
                rd_valid_d = 1'b0;
            end
            count_d = count_q + (ADDR_W+1)'(wr_acc) - n_load;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule
